stream_vector_source: RTL and testbench

Synthesizable valid/ready stream transmitter that replays a preloaded vector of `T`-bit words into the input port of a generated network (e.g. the `s_data_in_x`/`s_valid_x`/`s_ready_x` side of a `multi_*` top). It is the on-chip counterpart of the bench input driver: words are loaded through a write port, `start` launches the transfer, and an optional LFSR throttle inserts pseudo-random valid gaps. This gives hardware self-test with the same stimulus ordering and stall coverage as simulation.

---
 rtl/stream_vector_source_if.sv | 11 +
 rtl/stream_vector_source.sv | 120 ++++++++++++
 tb/tb_stream_vector_source.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_vector_source_if.sv
// Valid/ready stream bundle between the vector source and the network input port.
interface stream_vector_source_if #(
  parameter int unsigned T = 16
) ();
  logic [T-1:0] m_data_out_x;
  logic         m_valid_x;
  logic         m_ready_x;

  modport master (output m_data_out_x, output m_valid_x, input m_ready_x);
  modport slave  (input m_data_out_x, input m_valid_x, output m_ready_x);
endinterface

// File: rtl/stream_vector_source.sv
// Replays a preloaded vector of T-bit words onto a valid/ready stream, with an
// optional LFSR throttle that inserts pseudo-random valid gaps.
module stream_vector_source #(
  parameter int unsigned T         = 16,
  parameter int unsigned NUMVALS   = 9984,
  parameter int unsigned ADDRW     = $clog2(NUMVALS),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDRW-1:0]      wr_addr,
  input  logic [T-1:0]          wr_data,
  input  logic                  start,
  input  logic                  throttle_en,
  stream_vector_source_if.master m_if,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           count
);
  localparam int unsigned     IDXW     = ADDRW + 1;
  localparam logic [IDXW-1:0] NUM_IDX  = IDXW'(NUMVALS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [T-1:0]    mem [NUMVALS];
  logic [T-1:0]    dout_q;
  logic            valid_q, valid_d;
  logic            fetched_q, fetched_d;
  logic [IDXW-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]     count_q, count_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            rd_en;
  logic            hs;
  logic            gate;
  logic            wr_ok;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  assign lfsr_d = lfsr_step(lfsr_q);
  assign hs     = valid_q & m_if.m_ready_x;
  // New beats are judged against the LFSR value that will be current while they are shown.
  assign gate   = ~throttle_en | lfsr_d[0];
  assign wr_ok  = wr_en && (state_q != S_RUN) && (IDXW'(wr_addr) < NUM_IDX);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    fetched_d = fetched_q;
    rd_idx_d  = rd_idx_q;
    count_d   = count_q;
    rd_en     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          rd_idx_d  = '0;
          count_d   = '0;
          fetched_d = 1'b0;
          valid_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!fetched_q) begin
          rd_en     = 1'b1;
          fetched_d = 1'b1;
          rd_idx_d  = rd_idx_q + 1'b1;
        end else if (hs) begin
          count_d = count_q + 32'd1;
          // rd_idx_q already points past the word being sent.
          if (rd_idx_q == NUM_IDX) begin
            state_d   = S_DONE;
            valid_d   = 1'b0;
            fetched_d = 1'b0;
          end else begin
            rd_en    = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            valid_d  = gate;
          end
        end else if (!valid_q) begin
          valid_d = gate;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      fetched_q <= 1'b0;
      rd_idx_q  <= '0;
      count_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      fetched_q <= fetched_d;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
      lfsr_q    <= lfsr_d;
      if (rd_en) dout_q <= mem[rd_idx_q[ADDRW-1:0]];
    end
  end

  assign m_if.m_data_out_x = dout_q;
  assign m_if.m_valid_x    = valid_q;
  assign busy              = (state_q == S_RUN);
  assign done              = (state_q == S_DONE);
  assign count             = count_q;
endmodule

// File: tb/tb_stream_vector_source.sv
// Scoreboard bench: a small 4-word instance for directed timing/control cases and
// a full-size instance for a random-stall soak.
module tb_stream_vector_source;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 9984;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_wr_en = 0, a_start = 0, a_thr = 0, a_busy, a_done;
  logic [1:0]  a_wr_addr = '0;
  logic [15:0] a_wr_data = '0;
  logic [31:0] a_count;
  logic        b_wr_en = 0, b_start = 0, b_thr = 0, b_busy, b_done;
  logic [13:0] b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic [31:0] b_count;

  stream_vector_source_if #(.T(16)) a_if ();
  stream_vector_source_if #(.T(16)) b_if ();

  stream_vector_source #(.T(16), .NUMVALS(NA), .ADDRW(2), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .start(a_start), .throttle_en(a_thr), .m_if(a_if), .busy(a_busy), .done(a_done),
    .count(a_count));

  stream_vector_source #(.T(16), .NUMVALS(NB), .ADDRW(14), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .start(b_start), .throttle_en(b_thr), .m_if(b_if), .busy(b_busy), .done(b_done),
    .count(b_count));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference throttle LFSR, free-running from reset like the one in the block.
  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_ref(lfsr_m);

  logic [15:0] model_a [NA];
  logic [15:0] model_b [NB];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];

  logic a_pv = 0, a_phs = 0, b_pv = 0, b_phs = 0;
  logic [15:0] a_pd = '0, b_pd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_pv = 0; a_phs = 0;
    end else begin
      if (a_pv && !a_phs) begin
        chk("a_hold_valid", a_if.m_valid_x, 1);
        chk("a_hold_data", a_if.m_data_out_x, a_pd);
      end
      if (a_if.m_valid_x && (!a_pv || a_phs) && a_thr)
        chk("a_throttle_lfsr_bit0", lfsr_m[0], 1);
      if (a_if.m_valid_x && a_if.m_ready_x) begin
        chk("a_beat_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) chk("a_data", a_if.m_data_out_x, exp_a.pop_front());
      end
      a_pv = a_if.m_valid_x; a_phs = a_if.m_valid_x & a_if.m_ready_x; a_pd = a_if.m_data_out_x;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_pv = 0; b_phs = 0;
    end else begin
      if (b_pv && !b_phs) begin
        chk("b_hold_valid", b_if.m_valid_x, 1);
        chk("b_hold_data", b_if.m_data_out_x, b_pd);
      end
      if (b_if.m_valid_x && b_if.m_ready_x) begin
        chk("b_beat_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) chk("b_data", b_if.m_data_out_x, exp_b.pop_front());
      end
      b_pv = b_if.m_valid_x; b_phs = b_if.m_valid_x & b_if.m_ready_x; b_pd = b_if.m_data_out_x;
    end
  end

  task automatic load_a(input int idx, input logic [15:0] d);
    a_wr_en = 1; a_wr_addr = 2'(idx); a_wr_data = d; model_a[idx] = d;
    tick();
    a_wr_en = 0;
  endtask

  task automatic push_a();
    for (int i = 0; i < int'(NA); i++) exp_a.push_back(model_a[i]);
  endtask

  task automatic start_a();
    a_start = 1; tick(); a_start = 0;
  endtask

  task automatic wait_a_done(input int budget);
    int i = 0;
    while (i < budget && !a_done) begin tick(); i++; end
    chk("a_done_within_budget", a_done, 1);
  endtask

  initial begin
    a_if.m_ready_x = 1'b1;
    b_if.m_ready_x = 1'b0;
    tick(2);
    chk("rst_valid", a_if.m_valid_x, 0);
    chk("rst_data", a_if.m_data_out_x, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_count", a_count, 0);
    rst_n = 1;
    tick();

    load_a(0, 16'h0001); load_a(1, 16'h8000); load_a(2, 16'h7FFF); load_a(3, 16'hFFFF);

    // Full-rate replay with exact latency.
    push_a();
    start_a();
    chk("t1_busy_after_start", a_busy, 1);
    chk("t1_valid_k", a_if.m_valid_x, 0);
    tick();
    chk("t1_valid_k1", a_if.m_valid_x, 0);
    tick();
    chk("t1_valid_k2", a_if.m_valid_x, 1);
    chk("t1_data_k2", a_if.m_data_out_x, 16'h0001);
    tick(4);
    chk("t1_done", a_done, 1);
    chk("t1_busy", a_busy, 0);
    chk("t1_valid_end", a_if.m_valid_x, 0);
    chk("t1_count", a_count, 4);
    chk("t1_queue_empty", exp_a.size(), 0);

    // Backpressure on word 1.
    push_a();
    start_a();
    tick(3);
    a_if.m_ready_x = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_valid", a_if.m_valid_x, 1);
      chk("t2_stall_data", a_if.m_data_out_x, 16'h8000);
    end
    a_if.m_ready_x = 1'b1;
    wait_a_done(50);
    chk("t2_count", a_count, 4);
    chk("t2_queue_empty", exp_a.size(), 0);

    // LFSR throttle.
    a_thr = 1;
    push_a();
    start_a();
    wait_a_done(300);
    a_thr = 0;
    chk("t3_count", a_count, 4);
    chk("t3_queue_empty", exp_a.size(), 0);

    // Asynchronous reset after two beats.
    push_a();
    start_a();
    tick(4);
    #2 rst_n = 0;
    #1;
    chk("t4_rst_valid", a_if.m_valid_x, 0);
    chk("t4_rst_data", a_if.m_data_out_x, 0);
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_done", a_done, 0);
    chk("t4_rst_count", a_count, 0);
    exp_a.delete();
    tick();
    rst_n = 1;
    tick();
    push_a();
    start_a();
    wait_a_done(50);
    chk("t4_count", a_count, 4);
    chk("t4_queue_empty", exp_a.size(), 0);

    // start and wr_en held through a run, including the final handshake edge.
    push_a();
    a_start = 1;
    tick();
    a_wr_en = 1; a_wr_addr = 2'd0; a_wr_data = 16'h1234;
    tick(6);
    a_start = 0; a_wr_en = 0;
    chk("t5_done_despite_start", a_done, 1);
    chk("t5_busy", a_busy, 0);
    chk("t5_count", a_count, 4);
    chk("t5_queue_empty", exp_a.size(), 0);
    push_a();
    start_a();
    wait_a_done(50);
    chk("t5_rerun_queue_empty", exp_a.size(), 0);
    load_a(0, 16'h1234);
    push_a();
    start_a();
    wait_a_done(50);
    chk("t5_new_count", a_count, 4);
    chk("t5_new_queue_empty", exp_a.size(), 0);

    // Full-size soak with random backpressure.
    b_wr_en = 1;
    for (int i = 0; i < int'(NB); i++) begin
      b_wr_addr = 14'(i);
      b_wr_data = 16'($urandom);
      model_b[i] = b_wr_data;
      tick();
    end
    b_wr_en = 0;
    for (int i = 0; i < int'(NB); i++) exp_b.push_back(model_b[i]);
    b_start = 1; tick(); b_start = 0;
    begin
      int i = 0;
      while (i < 50000 && !b_done) begin
        b_if.m_ready_x = 1'($urandom_range(0, 1));
        tick();
        i++;
      end
    end
    chk("b_done_within_budget", b_done, 1);
    chk("b_count", b_count, NB);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
